pp_accumulator: RTL and testbench

//  Consumer end of the partial-product interface: accepts the WIDTH shifted 2*WIDTH-bit

---
 rtl/pp_accumulator.sv | 140 ++++++++++++++
 tb/tb_pp_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pp_accumulator.sv
// Partial-product accumulator: latches WIDTH partial products and sums them PP_PER_CYCLE
// per cycle into a 2*WIDTH-bit product. Define PP_ACC_CSA_EN for the carry-save variant.
module pp_accumulator #(
   parameter int WIDTH        = 16,
   parameter int PP_PER_CYCLE = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH*2*WIDTH-1:0] pp_flat,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       product,
   output logic                     busy
);

   localparam int PW       = 2 * WIDTH;
   localparam int N_GROUPS = WIDTH / PP_PER_CYCLE;
   localparam int IDXW     = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DONE} state_t;

   state_t                      r_state;
   logic [WIDTH-1:0][PW-1:0]    r_pp;
   logic [IDXW-1:0]             r_idx;
   logic [PW-1:0]               r_product;
   logic                        r_in_ready;
   logic                        r_out_valid;
   logic                        r_busy;
   logic                        w_last;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign busy      = r_busy;
   assign w_last    = (r_idx == IDXW'(N_GROUPS - 1));

`ifdef PP_ACC_CSA_EN
   logic [PW-1:0] r_sum, r_carry;
   logic [PW-1:0] w_sum, w_carry, w_cn;

   // The current group always sits in the low PP_PER_CYCLE slots; fold it in with a 3:2 chain.
   always_comb begin
      w_sum   = r_sum;
      w_carry = r_carry;
      w_cn    = '0;
      for (int j = 0; j < PP_PER_CYCLE; j++) begin
         w_cn    = ((w_sum & w_carry) | (w_sum & r_pp[j]) | (w_carry & r_pp[j])) << 1;
         w_sum   = w_sum ^ w_carry ^ r_pp[j];
         w_carry = w_cn;
      end
   end
`else
   logic [PW-1:0] r_acc;
   logic [PW-1:0] w_acc_nxt;

   always_comb begin
      w_acc_nxt = r_acc;
      for (int j = 0; j < PP_PER_CYCLE; j++)
         w_acc_nxt = w_acc_nxt + r_pp[j];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pp        <= '0;
         r_idx       <= '0;
         r_product   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef PP_ACC_CSA_EN
         r_sum       <= '0;
         r_carry     <= '0;
`else
         r_acc       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_pp       <= pp_flat;
                  r_idx      <= '0;
`ifdef PP_ACC_CSA_EN
                  r_sum      <= '0;
                  r_carry    <= '0;
`else
                  r_acc      <= '0;
`endif
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               // Shift consumed terms out so the next group lands in the low slots.
               r_pp  <= r_pp >> (PP_PER_CYCLE * PW);
               r_idx <= r_idx + IDXW'(1);
`ifdef PP_ACC_CSA_EN
               r_sum   <= w_sum;
               r_carry <= w_carry;
               if (w_last)
                  r_state <= S_FINAL;
`else
               r_acc <= w_acc_nxt;
               if (w_last) begin
                  r_product   <= w_acc_nxt;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
`endif
            end
`ifdef PP_ACC_CSA_EN
            S_FINAL: begin
               r_product   <= r_sum + r_carry;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pp_accumulator.sv
// Bench for pp_accumulator: vector table plus stall, mid-op reset and back-to-back sequences,
// checked through an expected-result queue.
module tb_pp_accumulator;
   localparam int W   = 16;
   localparam int PPC = 4;
   localparam int NG  = W / PPC;
   localparam int PW  = 2 * W;
`ifdef PP_ACC_CSA_EN
   localparam int LAT = NG + 1;
`else
   localparam int LAT = NG;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [W*PW-1:0] pp_flat = '0;
   logic            in_ready, out_valid, busy;
   logic [PW-1:0]   product;

   pp_accumulator #(.WIDTH(W), .PP_PER_CYCLE(PPC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pp_flat(pp_flat), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            n_acc  = 0;
   int            n_done = 0;
   logic [PW-1:0] cur_exp = '0;
   logic [PW-1:0] sb[$];

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] exp;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W*PW-1:0] mk_pp(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W*PW-1:0] r;
      r = '0;
      for (int k = 0; k < W; k++)
         if (a[k]) r[k*PW +: PW] = PW'(b) << k;
      return r;
   endfunction

   // Push on accept, pop and compare on each completed output handshake.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         sb.push_back(cur_exp);
         n_acc++;
      end
      if (rst_n && out_valid && out_ready) begin
         n_done++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got product %h with no op outstanding", product);
         end else begin
            chk("product", product, sb.pop_front());
         end
      end
   end

   task automatic send(input logic [W*PW-1:0] pp, input logic [PW-1:0] e, input string nm);
      int a0, lat;
      pp_flat = pp;
      cur_exp = e;
      in_valid = 1'b1;
      a0 = n_acc;
      for (int i = 0; i < 50 && n_acc == a0; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (n_acc == a0) begin
         chk({nm, "_accept_timeout"}, PW'(0), PW'(1));
         return;
      end
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, PW'(lat), PW'(LAT));
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) begin
         @(posedge clk); #1;
      end
      if (sb.size() != 0 || out_valid)
         chk({nm, "_drain_timeout"}, PW'(sb.size()), PW'(0));
   endtask

   initial begin
      logic ok;
      int   a0, d0;
      logic [W-1:0] ba[4];
      logic [W-1:0] bb[4];

      vecs[0] = '{16'd3,    16'd5,    32'h0000000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{16'd7,    16'd9,    32'd63};
      vecs[3] = '{16'h1234, 16'h5678, 32'h06260060};
      vecs[4] = '{16'h0000, 16'hBEEF, 32'h00000000};
      vecs[5] = '{16'h8000, 16'h0002, 32'h00010000};
      vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
      vecs[7] = '{16'h0001, 16'h0001, 32'h00000001};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  PW'(in_ready),  PW'(1));
      chk("rst_out_valid", PW'(out_valid), PW'(0));
      chk("rst_product",   product,        PW'(0));
      chk("rst_busy",      PW'(busy),      PW'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         send(mk_pp(vecs[i].a, vecs[i].b), vecs[i].exp, "vec");
         drain("vec");
      end

      // Every PP all-ones: 16 * (2^32-1) wraps to 2^32-16.
      send({W{32'hFFFFFFFF}}, 32'hFFFFFFF0, "raw");
      drain("raw");

      // Output stall: result must hold and no new accept until released.
      out_ready = 1'b0;
      send(mk_pp(16'h00FF, 16'h0101), 32'h0000FFFF, "stall");
      ok = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (!(out_valid === 1'b1 && in_ready === 1'b0 && busy === 1'b1 && product === 32'h0000FFFF))
            ok = 1'b0;
      end
      chk("stall_hold", PW'(ok), PW'(1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_valid", PW'(out_valid), PW'(0));
      chk("stall_release_ready", PW'(in_ready),  PW'(1));

      // Reset in the second ACCUM cycle aborts the op.
      pp_flat  = mk_pp(16'hABCD, 16'h1234);
      cur_exp  = 32'h0C374FA4;
      a0       = n_acc;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("abort_accepted", PW'(n_acc - a0), PW'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_product",   product,        PW'(0));
      chk("abort_in_ready",  PW'(in_ready),  PW'(1));
      chk("abort_out_valid", PW'(out_valid), PW'(0));
      chk("abort_busy",      PW'(busy),      PW'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (LAT + 3) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      chk("abort_no_out_valid", PW'(ok), PW'(1));
      send(mk_pp(16'd7, 16'd9), 32'd63, "after_abort");
      drain("after_abort");

      // Back-to-back with in_valid held high; pp_flat changes while the block is busy.
      ba = '{16'h0003, 16'hFFFF, 16'h1234, 16'h00A5};
      bb = '{16'h0005, 16'h8001, 16'h5678, 16'h5A00};
      a0 = n_acc;
      d0 = n_done;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int c0;
         pp_flat = mk_pp(ba[i], bb[i]);
         cur_exp = PW'(ba[i]) * PW'(bb[i]);
         c0 = n_acc;
         for (int t = 0; t < 50 && n_acc == c0; t++) begin
            @(posedge clk); #1;
         end
         if (n_acc == c0) chk("b2b_accept_timeout", PW'(i), PW'(4));
      end
      pp_flat = {W{32'h5A5A5A5A}};
      in_valid = 1'b0;
      drain("b2b");
      chk("b2b_accepts", PW'(n_acc - a0),  PW'(4));
      chk("b2b_done",    PW'(n_done - d0), PW'(4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
